// File: rtl/layer_sequencer_if.sv
// ---------------------------------------------------------------------------
// layer_sequencer_if
//   Bundles the handshake between the layer sequencer and the MNIST
//   accelerator control unit (cu).
//
//   master modport (sequencer side):
//     out cuGo            one-cycle go pulse
//     out cuLayerIndex    layer index presented to the cu
//     out cuData*/cuWeight*/cuResultAddress  descriptor of the current layer
//     out cuSoftRstn      active-low soft reset request for the cu
//     in  cuDone          done pulse from the cu
//   slave modport (cu side): the same signals with directions reversed.
// ---------------------------------------------------------------------------
interface layer_sequencer_if #(
    parameter int ADDR_W = 32
);
    logic              cuGo;
    logic [2:0]        cuLayerIndex;
    logic [ADDR_W-1:0] cuDataAddress;
    logic [ADDR_W-1:0] cuDataSize;
    logic [ADDR_W-1:0] cuWeightAddress;
    logic [ADDR_W-1:0] cuWeightSize;
    logic [ADDR_W-1:0] cuResultAddress;
    logic              cuDone;
    logic              cuSoftRstn;

    modport master (
        output cuGo,
        output cuLayerIndex,
        output cuDataAddress,
        output cuDataSize,
        output cuWeightAddress,
        output cuWeightSize,
        output cuResultAddress,
        output cuSoftRstn,
        input  cuDone
    );

    modport slave (
        input  cuGo,
        input  cuLayerIndex,
        input  cuDataAddress,
        input  cuDataSize,
        input  cuWeightAddress,
        input  cuWeightSize,
        input  cuResultAddress,
        input  cuSoftRstn,
        output cuDone
    );
endinterface

// File: rtl/layer_sequencer.sv
// ---------------------------------------------------------------------------
// layer_sequencer
//   Runs layers first..last of the MNIST accelerator back-to-back from a
//   software-loaded descriptor table, so software issues one start per image.
//   Provides a per-layer watchdog, software abort and a cu soft-reset request.
//
//   clk, rstn       clock, synchronous active-low reset
//   i_cfgWe         descriptor write strobe (ignored while busy)
//   i_cfgLayer      descriptor slot
//   i_cfgField      0=data_addr 1=data_size 2=weight_addr 3=weight_size 4=result_addr
//   i_cfgWdata      descriptor write data
//   i_firstLayer    first layer of the run, sampled at start
//   i_lastLayer     last layer of the run, sampled at start
//   i_start         run request, sampled only in IDLE
//   i_abort         cancel the current run
//   o_busy          run in progress
//   o_seqDone       one-cycle pulse on successful completion
//   o_error         sticky error flag (cleared by the next accepted start)
//   o_errCode       1=bad range 2=timeout 3=aborted
//   o_curLayer      layer being executed / last executed
//   cu              master side of the cu handshake
// ---------------------------------------------------------------------------
module layer_sequencer #(
    parameter int NUM_LAYERS     = 5,
    parameter int ADDR_W         = 32,
    parameter int TIMEOUT_CYCLES = 1048576
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              i_cfgWe,
    input  logic [2:0]        i_cfgLayer,
    input  logic [2:0]        i_cfgField,
    input  logic [ADDR_W-1:0] i_cfgWdata,
    input  logic [2:0]        i_firstLayer,
    input  logic [2:0]        i_lastLayer,
    input  logic              i_start,
    input  logic              i_abort,
    output logic              o_busy,
    output logic              o_seqDone,
    output logic              o_error,
    output logic [1:0]        o_errCode,
    output logic [2:0]        o_curLayer,
    layer_sequencer_if.master cu
);

    localparam int         NUM_FIELDS  = 5;
    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_RANGE   = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT = 2'd2;
    localparam logic [1:0] ERR_ABORT   = 2'd3;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        NEXT,
        CURST
    } state_t;

    state_t            r_state,       w_stateNext;
    logic              r_busy,        w_busyNext;
    logic              r_seqDone,     w_seqDoneNext;
    logic              r_error,       w_errorNext;
    logic [1:0]        r_errCode,     w_errCodeNext;
    logic [2:0]        r_curLayer,    w_curLayerNext;
    logic [2:0]        r_lastLayer,   w_lastLayerNext;
    logic              r_cuGo,        w_cuGoNext;
    logic              r_cuSoftRstn,  w_cuSoftRstnNext;
    logic              r_rstCnt,      w_rstCntNext;
    logic [31:0]       r_wdog,        w_wdogNext;

    logic [ADDR_W-1:0] r_desc [NUM_FIELDS][NUM_LAYERS];
    logic [ADDR_W-1:0] r_cuField [NUM_FIELDS];
    logic [ADDR_W-1:0] w_cuFieldNext [NUM_FIELDS];

    logic              w_cfgAccept;
    logic              w_rangeOk;
    logic              w_wdogHit;

    assign w_cfgAccept = i_cfgWe && !r_busy
                         && (int'(i_cfgLayer) < NUM_LAYERS)
                         && (int'(i_cfgField) < NUM_FIELDS);

    assign w_rangeOk   = (i_firstLayer <= i_lastLayer) && (int'(i_lastLayer) < NUM_LAYERS);

    // A zero timeout disables the watchdog entirely.
    assign w_wdogHit   = (TIMEOUT_CYCLES != 0) && (r_wdog == 32'(TIMEOUT_CYCLES - 1));

    // Next-state and next-output logic; every registered output is computed here.
    always_comb begin
        w_stateNext      = r_state;
        w_busyNext       = r_busy;
        w_seqDoneNext    = 1'b0;
        w_errorNext      = r_error;
        w_errCodeNext    = r_errCode;
        w_curLayerNext   = r_curLayer;
        w_lastLayerNext  = r_lastLayer;
        w_cuGoNext       = 1'b0;
        w_cuSoftRstnNext = 1'b1;
        w_rstCntNext     = 1'b0;
        w_wdogNext       = r_wdog;

        case (r_state)
            IDLE: begin
                if (i_start) begin
                    if (w_rangeOk) begin
                        w_stateNext     = ISSUE;
                        w_busyNext      = 1'b1;
                        w_curLayerNext  = i_firstLayer;
                        w_lastLayerNext = i_lastLayer;
                        w_errorNext     = 1'b0;
                        w_errCodeNext   = ERR_NONE;
                        w_cuGoNext      = 1'b1;
                    end else begin
                        w_errorNext     = 1'b1;
                        w_errCodeNext   = ERR_RANGE;
                    end
                end
            end

            // cu_done arriving here belongs to no layer and is ignored.
            ISSUE: begin
                w_wdogNext = '0;
                if (i_abort) begin
                    w_stateNext      = CURST;
                    w_errCodeNext    = ERR_ABORT;
                    w_cuSoftRstnNext = 1'b0;
                end else begin
                    w_stateNext      = WAIT;
                end
            end

            // Abort outranks both done and timeout in the same cycle.
            WAIT: begin
                w_wdogNext = r_wdog + 32'd1;
                if (i_abort) begin
                    w_stateNext      = CURST;
                    w_errCodeNext    = ERR_ABORT;
                    w_cuSoftRstnNext = 1'b0;
                end else if (cu.cuDone) begin
                    if (r_curLayer == r_lastLayer) begin
                        w_stateNext   = IDLE;
                        w_busyNext    = 1'b0;
                        w_seqDoneNext = 1'b1;
                    end else begin
                        w_stateNext   = NEXT;
                    end
                end else if (w_wdogHit) begin
                    w_stateNext      = CURST;
                    w_errCodeNext    = ERR_TIMEOUT;
                    w_cuSoftRstnNext = 1'b0;
                end
            end

            // One idle cycle lets the cu settle before the next go.
            NEXT: begin
                if (i_abort) begin
                    w_stateNext      = CURST;
                    w_errCodeNext    = ERR_ABORT;
                    w_cuSoftRstnNext = 1'b0;
                end else begin
                    w_stateNext    = ISSUE;
                    w_curLayerNext = r_curLayer + 3'd1;
                    w_cuGoNext     = 1'b1;
                end
            end

            // Soft reset is held low for exactly two cycles.
            CURST: begin
                if (r_rstCnt) begin
                    w_stateNext = IDLE;
                    w_busyNext  = 1'b0;
                    w_errorNext = 1'b1;
                end else begin
                    w_rstCntNext     = 1'b1;
                    w_cuSoftRstnNext = 1'b0;
                end
            end

            default: begin
                w_stateNext = IDLE;
            end
        endcase
    end

    // The cu descriptor outputs are registered from the slot selected by the
    // next layer index, bypassing a same-cycle table write so they always
    // mirror the table without a one-cycle lag.
    always_comb begin
        for (int f = 0; f < NUM_FIELDS; f++) begin
            w_cuFieldNext[f] = r_desc[f][w_curLayerNext];
            if (w_cfgAccept && (i_cfgLayer == w_curLayerNext) && (int'(i_cfgField) == f)) begin
                w_cuFieldNext[f] = i_cfgWdata;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state      <= IDLE;
            r_busy       <= 1'b0;
            r_seqDone    <= 1'b0;
            r_error      <= 1'b0;
            r_errCode    <= ERR_NONE;
            r_curLayer   <= 3'd0;
            r_lastLayer  <= 3'd0;
            r_cuGo       <= 1'b0;
            r_cuSoftRstn <= 1'b1;
            r_rstCnt     <= 1'b0;
            r_wdog       <= '0;
        end else begin
            r_state      <= w_stateNext;
            r_busy       <= w_busyNext;
            r_seqDone    <= w_seqDoneNext;
            r_error      <= w_errorNext;
            r_errCode    <= w_errCodeNext;
            r_curLayer   <= w_curLayerNext;
            r_lastLayer  <= w_lastLayerNext;
            r_cuGo       <= w_cuGoNext;
            r_cuSoftRstn <= w_cuSoftRstnNext;
            r_rstCnt     <= w_rstCntNext;
            r_wdog       <= w_wdogNext;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int f = 0; f < NUM_FIELDS; f++) begin
                r_cuField[f] <= '0;
                for (int l = 0; l < NUM_LAYERS; l++) begin
                    r_desc[f][l] <= '0;
                end
            end
        end else begin
            if (w_cfgAccept) begin
                r_desc[i_cfgField][i_cfgLayer] <= i_cfgWdata;
            end
            for (int f = 0; f < NUM_FIELDS; f++) begin
                r_cuField[f] <= w_cuFieldNext[f];
            end
        end
    end

    assign o_busy      = r_busy;
    assign o_seqDone   = r_seqDone;
    assign o_error     = r_error;
    assign o_errCode   = r_errCode;
    assign o_curLayer  = r_curLayer;

    assign cu.cuGo            = r_cuGo;
    assign cu.cuLayerIndex    = r_curLayer;
    assign cu.cuDataAddress   = r_cuField[0];
    assign cu.cuDataSize      = r_cuField[1];
    assign cu.cuWeightAddress = r_cuField[2];
    assign cu.cuWeightSize    = r_cuField[3];
    assign cu.cuResultAddress = r_cuField[4];
    assign cu.cuSoftRstn      = r_cuSoftRstn;

endmodule

// File: tb/tb_layer_sequencer.sv
// ---------------------------------------------------------------------------
// tb_layer_sequencer
//   Drives two sequencers: the main one (long watchdog) runs full, partial,
//   invalid, aborted and randomized image runs against a cu responder that
//   answers each go after a chosen latency; the second one (16-cycle
//   watchdog) never receives cu_done and exercises the timeout path.
//   Expected go times, indices and descriptors come from a plain model of
//   the descriptor table and the documented cycle costs.
// ---------------------------------------------------------------------------
module tb_layer_sequencer;

    localparam int NL = 5;
    localparam int AW = 32;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          cfgWe = 1'b0;
    logic [2:0]    cfgLayer = 3'd0;
    logic [2:0]    cfgField = 3'd0;
    logic [AW-1:0] cfgWdata = '0;
    logic [2:0]    firstLayer = 3'd0;
    logic [2:0]    lastLayer = 3'd0;
    logic          start = 1'b0;
    logic          abortReq = 1'b0;
    logic          startWd = 1'b0;
    logic          abortWd = 1'b0;

    logic          busy, seqDone, errorFlag;
    logic [1:0]    errCode;
    logic [2:0]    curLayer;
    logic          busyWd, seqDoneWd, errorWd;
    logic [1:0]    errCodeWd;
    logic [2:0]    curLayerWd;

    layer_sequencer_if #(.ADDR_W(AW)) cuBus();
    layer_sequencer_if #(.ADDR_W(AW)) cuBusWd();

    layer_sequencer #(.NUM_LAYERS(NL), .ADDR_W(AW), .TIMEOUT_CYCLES(1000)) dut (
        .clk(clk), .rstn(rstn),
        .i_cfgWe(cfgWe), .i_cfgLayer(cfgLayer), .i_cfgField(cfgField), .i_cfgWdata(cfgWdata),
        .i_firstLayer(firstLayer), .i_lastLayer(lastLayer),
        .i_start(start), .i_abort(abortReq),
        .o_busy(busy), .o_seqDone(seqDone), .o_error(errorFlag), .o_errCode(errCode),
        .o_curLayer(curLayer), .cu(cuBus)
    );

    layer_sequencer #(.NUM_LAYERS(NL), .ADDR_W(AW), .TIMEOUT_CYCLES(TO)) dutWd (
        .clk(clk), .rstn(rstn),
        .i_cfgWe(cfgWe), .i_cfgLayer(cfgLayer), .i_cfgField(cfgField), .i_cfgWdata(cfgWdata),
        .i_firstLayer(firstLayer), .i_lastLayer(lastLayer),
        .i_start(startWd), .i_abort(abortWd),
        .o_busy(busyWd), .o_seqDone(seqDoneWd), .o_error(errorWd), .o_errCode(errCodeWd),
        .o_curLayer(curLayerWd), .cu(cuBusWd)
    );

    always #5 clk = ~clk;

    typedef struct {
        int            cyc;
        logic [2:0]    idx;
        logic [AW-1:0] fld [5];
    } goRec_t;

    goRec_t        goQ[$];
    logic [AW-1:0] descModel [5][NL];

    int nChecks = 0;
    int nPass   = 0;
    int cyc     = 0;
    int lat, abortIdx, midWriteIdx, doneAt, abortAt;
    bit spurious;
    int seqDoneCnt, seqDoneCyc;
    logic seqDoneBusy;
    int rstLowCnt, rstLowFirst, rstLowCntWd, rstLowFirstWd, seqDoneWdCnt;

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        nChecks++;
        if (actual === expected) nPass++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    endtask

    // One clock: observe outputs mid-cycle, then act as the cu for this cycle.
    task automatic tick();
        goRec_t r;
        @(negedge clk);
        cyc++;
        cfgWe = 1'b0;
        if (cuBus.cuGo) begin
            r.cyc    = cyc;
            r.idx    = cuBus.cuLayerIndex;
            r.fld[0] = cuBus.cuDataAddress;
            r.fld[1] = cuBus.cuDataSize;
            r.fld[2] = cuBus.cuWeightAddress;
            r.fld[3] = cuBus.cuWeightSize;
            r.fld[4] = cuBus.cuResultAddress;
            goQ.push_back(r);
            doneAt = cyc + lat;
            if (int'(cuBus.cuLayerIndex) == abortIdx) abortAt = cyc + lat;
            if (int'(cuBus.cuLayerIndex) == midWriteIdx) begin
                cfgWe    = 1'b1;
                cfgLayer = 3'd2;
                cfgField = 3'd0;
                cfgWdata = 32'hDEAD_0000 | AW'($urandom_range(1, 255));
            end
        end
        if (seqDone) begin
            seqDoneCnt++;
            seqDoneCyc  = cyc;
            seqDoneBusy = busy;
        end
        if (!cuBus.cuSoftRstn) begin
            if (rstLowCnt == 0) rstLowFirst = cyc;
            rstLowCnt++;
        end
        if (!cuBusWd.cuSoftRstn) begin
            if (rstLowCntWd == 0) rstLowFirstWd = cyc;
            rstLowCntWd++;
        end
        if (seqDoneWd) seqDoneWdCnt++;
        cuBus.cuDone = (cyc == doneAt) || (spurious && cuBus.cuGo);
        abortReq     = (cyc == abortAt);
    endtask

    task automatic writeDesc(input int layer, input int field, input logic [AW-1:0] data);
        cfgWe    = 1'b1;
        cfgLayer = 3'(layer);
        cfgField = 3'(field);
        cfgWdata = data;
        if (layer < NL && field < 5) descModel[field][layer] = data;
        tick();
    endtask

    // One image run from start to return to idle, checked against the model.
    task automatic applyStimulus(input int f, input int l, input int latency, input int abortLayer,
                                 input bit spur, input int writeLayer, input string tag);
        int s, n, lastRun, lastGo, k;
        bit valid, ended, aborted;
        goQ.delete();
        seqDoneCnt = 0; seqDoneCyc = -1; seqDoneBusy = 1'b1;
        rstLowCnt = 0; rstLowFirst = -1;
        lat = latency; abortIdx = abortLayer; spurious = spur; midWriteIdx = writeLayer;
        doneAt = -1; abortAt = -1;
        firstLayer = 3'(f);
        lastLayer  = 3'(l);
        start = 1'b1;
        s = cyc;
        tick();
        start = 1'b0;
        ended = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (!busy) begin
                ended = 1'b1;
                break;
            end
            tick();
        end
        checkOutput({tag, ".ended"}, ended, 1);
        valid = (f <= l) && (l < NL);
        if (!valid) begin
            checkOutput({tag, ".goCount"}, goQ.size(), 0);
            checkOutput({tag, ".error"}, errorFlag, 1);
            checkOutput({tag, ".errCode"}, errCode, 1);
            checkOutput({tag, ".busy"}, busy, 0);
            return;
        end
        aborted = (abortLayer >= f) && (abortLayer <= l);
        lastRun = aborted ? abortLayer : l;
        n = lastRun - f + 1;
        checkOutput({tag, ".goCount"}, goQ.size(), n);
        for (int i = 0; i < n && i < goQ.size(); i++) begin
            k = f + i;
            checkOutput($sformatf("%s.go%0d.idx", tag, i), goQ[i].idx, k);
            checkOutput($sformatf("%s.go%0d.cycle", tag, i), goQ[i].cyc, s + 1 + i * (latency + 2));
            for (int j = 0; j < 5; j++)
                checkOutput($sformatf("%s.go%0d.field%0d", tag, i, j), goQ[i].fld[j], descModel[j][k]);
        end
        lastGo = s + 1 + (n - 1) * (latency + 2);
        if (aborted) begin
            checkOutput({tag, ".seqDoneCount"}, seqDoneCnt, 0);
            checkOutput({tag, ".softRstFirst"}, rstLowFirst, lastGo + latency + 1);
            checkOutput({tag, ".softRstLen"}, rstLowCnt, 2);
            checkOutput({tag, ".idleCycle"}, cyc, lastGo + latency + 3);
            checkOutput({tag, ".error"}, errorFlag, 1);
            checkOutput({tag, ".errCode"}, errCode, 3);
        end else begin
            checkOutput({tag, ".seqDoneCount"}, seqDoneCnt, 1);
            checkOutput({tag, ".seqDoneCycle"}, seqDoneCyc, lastGo + latency + 1);
            checkOutput({tag, ".busyAtDone"}, seqDoneBusy, 0);
            checkOutput({tag, ".error"}, errorFlag, 0);
            checkOutput({tag, ".errCode"}, errCode, 0);
            checkOutput({tag, ".softRstLen"}, rstLowCnt, 0);
        end
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL globalTimeout: simulation exceeded its time budget");
        $fatal(1, "[TB] time budget exceeded");
    end

    initial begin
        int s, f, l, a;
        bit ended;
        cuBus.cuDone   = 1'b0;
        cuBusWd.cuDone = 1'b0;
        lat = 1; abortIdx = -1; midWriteIdx = -1; doneAt = -1; abortAt = -1; spurious = 1'b0;
        rstLowCnt = 0; rstLowFirst = -1; rstLowCntWd = 0; rstLowFirstWd = -1; seqDoneWdCnt = 0;
        seqDoneCnt = 0; seqDoneCyc = -1; seqDoneBusy = 1'b0;
        for (int j = 0; j < 5; j++)
            for (int k = 0; k < NL; k++) descModel[j][k] = '0;

        $display("[TB] reset");
        repeat (3) tick();
        checkOutput("reset.busy", busy, 0);
        checkOutput("reset.seqDone", seqDone, 0);
        checkOutput("reset.error", errorFlag, 0);
        checkOutput("reset.errCode", errCode, 0);
        checkOutput("reset.curLayer", curLayer, 0);
        checkOutput("reset.cuGo", cuBus.cuGo, 0);
        checkOutput("reset.cuSoftRstn", cuBus.cuSoftRstn, 1);
        checkOutput("reset.cuDataAddress", cuBus.cuDataAddress, 0);
        checkOutput("reset.busyWd", busyWd, 0);
        rstn = 1'b1;
        tick();

        $display("[TB] load descriptors");
        for (int k = 0; k < NL; k++) begin
            writeDesc(k, 0, AW'(32'h100 * k));
            writeDesc(k, 1, AW'($urandom));
            writeDesc(k, 2, AW'($urandom));
            writeDesc(k, 3, AW'($urandom));
            writeDesc(k, 4, AW'(32'h1000 + k));
        end
        writeDesc(6, 0, AW'($urandom));
        writeDesc(1, 5, AW'($urandom));
        writeDesc(3, 7, AW'($urandom));

        applyStimulus(0, 4, 20, -1, 1'b0, -1, "full");
        applyStimulus(2, 3, $urandom_range(3, 15), -1, 1'b0, -1, "partial");
        applyStimulus(3, 1, 10, -1, 1'b0, -1, "badRange");
        applyStimulus(0, 4, 12, 1, 1'b0, -1, "abortWithDone");
        applyStimulus(1, 3, 10, -1, 1'b1, 1, "dropWrite");

        $display("[TB] randomized runs");
        for (int it = 0; it < 8; it++) begin
            writeDesc($urandom_range(0, 7), $urandom_range(0, 6), AW'($urandom));
            f = $urandom_range(0, 6);
            l = $urandom_range(0, 6);
            a = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 4) : -1;
            applyStimulus(f, l, $urandom_range(1, 20), a, 1'(($urandom_range(0, 1))), -1,
                          $sformatf("rand%0d", it));
        end

        $display("[TB] watchdog timeout");
        firstLayer = 3'd2;
        lastLayer  = 3'd2;
        rstLowCntWd = 0; rstLowFirstWd = -1; seqDoneWdCnt = 0;
        startWd = 1'b1;
        s = cyc;
        tick();
        startWd = 1'b0;
        ended = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (!busyWd) begin
                ended = 1'b1;
                break;
            end
            tick();
        end
        checkOutput("timeout.ended", ended, 1);
        checkOutput("timeout.softRstFirst", rstLowFirstWd, s + 2 + TO);
        checkOutput("timeout.softRstLen", rstLowCntWd, 2);
        checkOutput("timeout.idleCycle", cyc, s + 4 + TO);
        checkOutput("timeout.error", errorWd, 1);
        checkOutput("timeout.errCode", errCodeWd, 2);
        checkOutput("timeout.seqDoneCount", seqDoneWdCnt, 0);

        $display("[TB] reset mid-run");
        goQ.delete();
        lat = 100; abortIdx = -1; midWriteIdx = -1; spurious = 1'b0; doneAt = -1; abortAt = -1;
        firstLayer = 3'd0;
        lastLayer  = 3'd4;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (5) tick();
        checkOutput("midRun.busyBefore", busy, 1);
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        doneAt = -1;
        for (int j = 0; j < 5; j++)
            for (int k = 0; k < NL; k++) descModel[j][k] = '0;
        checkOutput("midRun.busy", busy, 0);
        checkOutput("midRun.cuGo", cuBus.cuGo, 0);
        checkOutput("midRun.cuDataAddress", cuBus.cuDataAddress, 0);
        checkOutput("midRun.cuResultAddress", cuBus.cuResultAddress, 0);
        checkOutput("midRun.curLayer", curLayer, 0);
        applyStimulus(0, 0, 5, -1, 1'b0, -1, "postReset");

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
